// File: rtl/timebin_pkg.sv
// ============================================================================
// timebin_pkg : shared types and constants for the time-bin count UART path.
// Optional feature macro: UART_PARITY_EN (even parity bit, 8E1 frame).
// Revision: 1.0
// ============================================================================
`default_nettype none

package timebin_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

`ifdef UART_PARITY_EN
   localparam int UART_FRAME_BITS = 11;
`else
   localparam int UART_FRAME_BITS = 10;
`endif

endpackage

`default_nettype wire

// File: rtl/count_fifo.sv
// ============================================================================
// count_fifo : synchronous FIFO with registered read data (valid the cycle
// after pop). A push while full is accepted only alongside a same-cycle pop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_fifo
   import timebin_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [WIDTH-1:0] dout_q;

   logic w_pop_ok;
   logic w_push_ok;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign w_pop_ok  = pop_i && !empty_o;
   assign w_push_ok = push_i && (!full_o || w_pop_ok);
   assign level_o   = level_q;
   assign dout_o    = dout_q;

   // Storage carries no reset; only pointers and level define contents.
   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
      end else begin
         if (w_push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            dout_q   <= mem_q[rd_ptr_q];
         end
         if (w_push_ok && !w_pop_ok) begin
            level_q <= level_q + LW'(1);
         end else if (!w_push_ok && w_pop_ok) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/timebin_count_uart_tx.sv
// ============================================================================
// timebin_count_uart_tx : buffers strobed 8-bit bin counts and sends them
// LSB-first as UART 8N1 (8E1 when UART_PARITY_EN is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module timebin_count_uart_tx
   import timebin_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          bin_valid_i,
   input  logic [7:0]                    bin_count_i,
   input  logic                          overflow_clr_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);

   tx_state_t   state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]  bit_q;
   logic [6:0]  shift_q;
   logic        tx_q;
   logic        busy_q;
   logic        ovf_q;
   logic        ovf_d;
`ifdef UART_PARITY_EN
   logic        parity_q;
`endif

   logic        w_baud_last;
   logic        w_pop;
   logic        w_push;
   logic        w_drop;
   logic [7:0]  w_fifo_dout;
   logic        w_fifo_full;
   logic        w_fifo_empty;

   assign w_baud_last = (baud_q == BAUD_LAST);
   // Pop from IDLE, or on the last STOP cycle so the next START follows with no gap.
   assign w_pop  = !w_fifo_empty &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_baud_last));
   assign w_push = bin_valid_i && (!w_fifo_full || w_pop);
   assign w_drop = bin_valid_i && w_fifo_full && !w_pop;

   count_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   (bin_count_i),
      .dout_o  (w_fifo_dout),
      .level_o (fifo_level_o),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   always_comb begin
      ovf_d = ovf_q;
      if (w_drop) begin
         ovf_d = 1'b1;
      end else if (overflow_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         baud_q <= w_baud_last ? '0 : baud_q + CW'(1);
         unique case (state_q)
            ST_IDLE: begin
               baud_q <= '0;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (!w_fifo_empty) begin
                  state_q <= ST_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               // Popped data is valid from the first START cycle; latch it at the bit edge.
               if (w_baud_last) begin
                  state_q  <= ST_DATA;
                  tx_q     <= w_fifo_dout[0];
                  shift_q  <= w_fifo_dout[7:1];
                  bit_q    <= '0;
`ifdef UART_PARITY_EN
                  parity_q <= ^w_fifo_dout;
`endif
               end
            end
            ST_DATA: begin
               if (w_baud_last) begin
                  if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                     state_q <= ST_PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
               if (w_baud_last) begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (w_baud_last) begin
                  if (!w_fifo_empty) begin
                     state_q <= ST_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_o       = tx_q;
   assign busy_o     = busy_q;
   assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_timebin_count_uart_tx.sv
// ============================================================================
// tb_timebin_count_uart_tx : bench for timebin_count_uart_tx, 10 clks/bit,
// 4-entry FIFO. Honours UART_PARITY_EN for the expected frame shape.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timebin_count_uart_tx;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int DEPTH  = 4;
   localparam int CPB    = 10;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CLKS = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bin_valid = 1'b0;
   logic [7:0] bin_count = 8'h00;
   logic       overflow_clr = 1'b0;
   wire        tx;
   wire        busy;
   wire  [2:0] fifo_level;
   wire        overflow;

   always #5 clk = ~clk;

   timebin_count_uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .bin_valid_i    (bin_valid),
      .bin_count_i    (bin_count),
      .overflow_clr_i (overflow_clr),
      .tx_o           (tx),
      .busy_o         (busy),
      .fifo_level_o   (fifo_level),
      .overflow_o     (overflow)
   );

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   vec_t exp_q[$];
   vec_t vecs[6];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // ---------------- serial monitor / scoreboard ----------------
   logic        mon_en  = 1'b1;
   logic        mon_act = 1'b0;
   int          mon_pos = 0;
   int          mon_b   = 0;
   int          cyc     = 0;
   logic [10:0] mon_bits = '0;
   int          starts[$];

   task automatic frame_done();
      vec_t e;
      check("start_bit", 32'(mon_bits[0]), 32'd0);
      check("stop_bit", 32'(mon_bits[FRAME_BITS-1]), 32'd1);
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_frame: got data %0h, required no frame", mon_bits[8:1]);
      end else begin
         e = exp_q.pop_front();
         check("frame_data", 32'(mon_bits[8:1]), 32'(e.data));
`ifdef UART_PARITY_EN
         check("parity_bit", 32'(mon_bits[9]), 32'(e.par));
`endif
      end
   endtask

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!mon_en) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_pos = 1;
            starts.push_back(cyc);
         end
      end else begin
         mon_pos = mon_pos + 1;
         if (mon_pos % CPB == CPB / 2) begin
            mon_b = mon_pos / CPB;
            mon_bits[mon_b] = tx;
            check("busy_in_frame", 32'(busy), 32'd1);
            if (mon_b == FRAME_BITS - 1) begin
               frame_done();
               mon_act = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic strobe(input logic [7:0] d, input logic par, input bit accept);
      bin_count = d;
      bin_valid = 1'b1;
      if (accept) exp_q.push_back('{d, par});
      @(negedge clk);
      bin_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int d01;
   int d12;

   initial begin
      vecs[0] = '{8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0};
      vecs[3] = '{8'h07, 1'b1};
      vecs[4] = '{8'h03, 1'b0};
      vecs[5] = '{8'h80, 1'b1};

      // reset state
      idle(2);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      idle(2);

      // single-byte frames from the vector table
      for (int i = 0; i < 6; i++) begin
         strobe(vecs[i].data, vecs[i].par, 1'b1);
         check("single_level_after_push", 32'(fifo_level), 32'd1);
         check("single_busy_before", 32'(busy), 32'd0);
         idle(1);
         check("single_busy_rise", 32'(busy), 32'd1);
         check("single_tx_start", 32'(tx), 32'd0);
         check("single_level_after_pop", 32'(fifo_level), 32'd0);
         idle(FRAME_CLKS - 1);
         check("single_busy_last", 32'(busy), 32'd1);
         idle(1);
         check("single_busy_fall", 32'(busy), 32'd0);
         check("single_tx_idle", 32'(tx), 32'd1);
         idle(3);
      end
      check("table_all_frames", 32'(exp_q.size()), 32'd0);

      // burst of three on consecutive clocks; first entry already popped by the third push
      starts.delete();
      strobe(8'h01, 1'b1, 1'b1);
      strobe(8'h02, 1'b1, 1'b1);
      strobe(8'h03, 1'b0, 1'b1);
      check("burst_level", 32'(fifo_level), 32'd2);
      idle(3 * FRAME_CLKS + 10);
      check("burst_frames", 32'(starts.size()), 32'd3);
      check("burst_all_frames", 32'(exp_q.size()), 32'd0);
      if (starts.size() == 3) begin
         d01 = starts[1] - starts[0];
         d12 = starts[2] - starts[1];
         check("burst_gap1", 32'(d01 >= FRAME_CLKS && d01 <= FRAME_CLKS + 1), 32'd1);
         check("burst_gap2", 32'(d12 >= FRAME_CLKS && d12 <= FRAME_CLKS + 1), 32'd1);
      end

      // overflow: one frame on the line, six strobes into a 4-deep FIFO
      strobe(8'h5A, 1'b0, 1'b1);
      idle(4);
      for (int i = 0; i < 6; i++) begin
         strobe(8'h10 + 8'(i), ^(8'h10 + 8'(i)), (i < 4));
      end
      check("ovf_level_full", 32'(fifo_level), 32'd4);
      check("ovf_set", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      bin_count    = 8'h99;
      bin_valid    = 1'b1;
      overflow_clr = 1'b1;
      idle(1);
      bin_valid    = 1'b0;
      overflow_clr = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'd1);
      check("ovf_level_still_full", 32'(fifo_level), 32'd4);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("ovf_cleared2", 32'(overflow), 32'd0);
      idle(5 * FRAME_CLKS + 20);
      check("ovf_all_frames", 32'(exp_q.size()), 32'd0);
      check("ovf_drained", 32'(fifo_level), 32'd0);

      // push coincident with a pop while full
      strobe(8'hC1, 1'b1, 1'b1);
      idle(3);
      strobe(8'hC2, 1'b1, 1'b1);
      strobe(8'hC3, 1'b0, 1'b1);
      strobe(8'hC4, 1'b1, 1'b1);
      strobe(8'hC5, 1'b0, 1'b1);
      check("pp_level_full", 32'(fifo_level), 32'd4);
      idle(FRAME_CLKS + 1 - 8);
      check("pp_level_before", 32'(fifo_level), 32'd4);
      strobe(8'hC6, 1'b0, 1'b1);
      check("pp_level_kept", 32'(fifo_level), 32'd4);
      check("pp_no_overflow", 32'(overflow), 32'd0);
      idle(5 * FRAME_CLKS + 20);
      check("pp_all_frames", 32'(exp_q.size()), 32'd0);

      // reset in the middle of data bit 3
      strobe(8'hFF, 1'b0, 1'b0);
      strobe(8'h11, 1'b0, 1'b0);
      strobe(8'h22, 1'b0, 1'b0);
      idle(42);
      check("mid_busy_before_rst", 32'(busy), 32'd1);
      mon_en = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("arst_tx", 32'(tx), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      idle(1);
      reset  = 1'b0;
      idle(1);
      mon_en = 1'b1;
      idle(1);
      strobe(8'h3C, 1'b0, 1'b1);
      idle(FRAME_CLKS + 10);
      check("post_rst_frame", 32'(exp_q.size()), 32'd0);
      check("post_rst_level", 32'(fifo_level), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
